// File: rtl/tpu_pkg.sv
// Shared TPU types and constants: writeback FSM states, lane geometry,
// int8 saturation bounds and the byte-enable helper for partial lines.
package tpu_pkg;

  localparam int LANES   = 8;
  localparam int ACC_W   = 32;
  localparam int Q_W     = 8;
  localparam int ADDR_W  = 8;
  localparam int SHIFT_W = 5;
  localparam int SLOTS   = 4;
  localparam int WORD_W  = LANES * ACC_W;
  localparam int QWORD_W = LANES * Q_W;
  localparam int LINE_W  = SLOTS * QWORD_W;
  localparam int MASK_W  = LINE_W / 8;

  localparam int Q_MAX = 127;
  localparam int Q_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // One 0xFF byte-enable group per filled slot, starting at slot 0.
  function automatic logic [MASK_W-1:0] slot_mask(input logic [2:0] cnt);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (s < int'(cnt)) m[s*QWORD_W/8 +: QWORD_W/8] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One-lane requantizer: 33-bit (x + r) >>> shift, saturated to int8.
// WB_ROUND_EN adds r = 1 << (shift-1) for round-half-up; otherwise truncation.
module requant_lane
  import tpu_pkg::*;
(
  input  logic [ACC_W-1:0]   i_x,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [Q_W-1:0]     o_y
);

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(Q_MAX);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(Q_MIN);

  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shr;

`ifdef WB_ROUND_EN
  logic signed [ACC_W:0] w_rnd;

  always_comb begin
    w_rnd = '0;
    if (i_shift != '0) w_rnd = (ACC_W+1)'(1) << (i_shift - 1'b1);
  end

  assign w_sum = $signed({i_x[ACC_W-1], i_x}) + w_rnd;
`else
  assign w_sum = $signed({i_x[ACC_W-1], i_x});
`endif

  assign w_shr = w_sum >>> i_shift;

  always_comb begin
    o_y = w_shr[Q_W-1:0];
    if (w_shr > SAT_HI)      o_y = SAT_HI[Q_W-1:0];
    else if (w_shr < SAT_LO) o_y = SAT_LO[Q_W-1:0];
  end

endmodule

// File: rtl/ub_writeback.sv
// Requantizes VPU result words to int8, packs four words per unified-buffer
// line and writes lines to consecutive addresses. Macro: WB_ROUND_EN (rounding).
module ub_writeback
  import tpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_start,
  input  logic [ADDR_W-1:0]    wb_base_addr,
  input  logic [7:0]           wb_count,
  input  logic [SHIFT_W-1:0]   wb_shift,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 ub_wr_en,
  output logic [ADDR_W-1:0]    ub_wr_addr,
  output logic [LINE_W-1:0]    ub_wr_data,
  output logic [MASK_W-1:0]    ub_wr_mask,
  input  logic                 ub_wr_ready,
  output logic                 wb_busy,
  output logic                 wb_done,
  output logic                 wb_overflow,
  output wb_state_t            dbg_state
);

  // Write handshake: a line transfers on a cycle with ub_wr_en & ub_wr_ready;
  // while ub_wr_en is high and ready is low, en/addr/data/mask are held.
  // in_valid has no ready: a word that finds the pack register blocked is dropped.

  wb_state_t r_state, w_state_nxt;

  logic [7:0]          r_count;
  logic [7:0]          r_seen;
  logic [SHIFT_W-1:0]  r_shift;
  logic [ADDR_W-1:0]   r_next_addr;
  logic                r_overflow;

  logic                r_q_valid;
  logic                r_q_last;
  logic [QWORD_W-1:0]  r_q_data;
  logic [QWORD_W-1:0]  w_q_word;

  logic [LINE_W-1:0]   r_pack_data, w_pack_data_nxt;
  logic [2:0]          r_pack_cnt, w_pack_cnt_nxt;
  logic                r_pack_full, w_pack_full_nxt;

  logic                r_out_en;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [LINE_W-1:0]   r_out_data;
  logic [MASK_W-1:0]   r_out_mask;

  logic                w_start, w_accept, w_accept_last;
  logic                w_hs, w_out_free, w_xfer, w_blocked, w_drop, w_pack_wr;
  logic                w_fresh;
  logic [1:0]          w_slot;

  assign w_start       = wb_start && (r_state == IDLE);
  assign w_accept      = (r_state == RUN) && in_valid && (r_seen != r_count);
  assign w_accept_last = w_accept && ((r_seen + 8'd1) == r_count);

  assign w_hs       = r_out_en && ub_wr_ready;
  assign w_out_free = !r_out_en || ub_wr_ready;
  assign w_xfer     = r_pack_full && w_out_free;
  assign w_blocked  = r_pack_full && !w_out_free;
  assign w_drop     = r_q_valid && w_blocked;
  assign w_pack_wr  = r_q_valid && !w_blocked;
  assign w_fresh    = w_xfer || (r_pack_cnt == 3'd0);
  assign w_slot     = w_fresh ? 2'd0 : r_pack_cnt[1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane u_lane (
      .i_x     (in_data[g*ACC_W +: ACC_W]),
      .i_shift (r_shift),
      .o_y     (w_q_word[g*Q_W +: Q_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_start) w_state_nxt = (wb_count == 8'd0) ? DONE : RUN;
      RUN:   if (w_accept_last) w_state_nxt = FLUSH;
      FLUSH: if (w_hs && !r_pack_full && (r_pack_cnt == 3'd0) && !r_q_valid)
               w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_seen     <= '0;
      r_shift    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_count    <= wb_count;
      r_seen     <= '0;
      r_shift    <= wb_shift;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_seen <= r_seen + 8'd1;
      if (w_drop)   r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_q_last  <= 1'b0;
      r_q_data  <= '0;
    end else begin
      r_q_valid <= w_accept;
      if (w_accept) begin
        r_q_data <= w_q_word;
        r_q_last <= w_accept_last;
      end
    end
  end

  // A new line starts from zero so unfilled slots of a partial line read 0.
  always_comb begin
    w_pack_data_nxt = r_pack_data;
    w_pack_cnt_nxt  = r_pack_cnt;
    w_pack_full_nxt = r_pack_full;
    if (w_xfer) begin
      w_pack_cnt_nxt  = 3'd0;
      w_pack_full_nxt = 1'b0;
    end
    if (w_pack_wr) begin
      if (w_fresh) w_pack_data_nxt = '0;
      w_pack_data_nxt[int'(w_slot)*QWORD_W +: QWORD_W] = r_q_data;
      w_pack_cnt_nxt  = {1'b0, w_slot} + 3'd1;
      w_pack_full_nxt = (w_slot == 2'd3) || r_q_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack_data <= '0;
      r_pack_cnt  <= '0;
      r_pack_full <= 1'b0;
    end else begin
      r_pack_data <= w_pack_data_nxt;
      r_pack_cnt  <= w_pack_cnt_nxt;
      r_pack_full <= w_pack_full_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr <= '0;
      r_out_en    <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else begin
      if (w_start) begin
        r_next_addr <= wb_base_addr;
      end else if (w_xfer) begin
        r_next_addr <= r_next_addr + 1'b1;
      end
      if (w_xfer) begin
        r_out_en   <= 1'b1;
        r_out_addr <= r_next_addr;
        r_out_data <= r_pack_data;
        r_out_mask <= slot_mask(r_pack_cnt);
      end else if (w_hs) begin
        r_out_en <= 1'b0;
      end
    end
  end

  assign ub_wr_en    = r_out_en;
  assign ub_wr_addr  = r_out_addr;
  assign ub_wr_data  = r_out_data;
  assign ub_wr_mask  = r_out_mask;
  assign wb_busy     = (r_state != IDLE);
  assign wb_done     = (r_state == DONE);
  assign wb_overflow = r_overflow;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ub_writeback.sv
// Self-checking bench for ub_writeback: directed jobs plus random jobs, with
// expected lines queued at drive time and compared at each write handshake.
module tb_ub_writeback;
  import tpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              wb_start;
  logic [7:0]        wb_base_addr;
  logic [7:0]        wb_count;
  logic [4:0]        wb_shift;
  logic [255:0]      in_data;
  logic              in_valid;
  logic              ub_wr_en;
  logic [7:0]        ub_wr_addr;
  logic [255:0]      ub_wr_data;
  logic [31:0]       ub_wr_mask;
  logic              ub_wr_ready;
  logic              wb_busy;
  logic              wb_done;
  logic              wb_overflow;
  wb_state_t         dbg_state;

  ub_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_start     (wb_start),
    .wb_base_addr (wb_base_addr),
    .wb_count     (wb_count),
    .wb_shift     (wb_shift),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .ub_wr_en     (ub_wr_en),
    .ub_wr_addr   (ub_wr_addr),
    .ub_wr_data   (ub_wr_data),
    .ub_wr_mask   (ub_wr_mask),
    .ub_wr_ready  (ub_wr_ready),
    .wb_busy      (wb_busy),
    .wb_done      (wb_done),
    .wb_overflow  (wb_overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / counters ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [295:0] exp_q[$];   // {addr[7:0], mask[31:0], data[255:0]}
  logic [255:0] words[0:31];

  int hs_count = 0;
  int last_hs_cyc = 0;
  int last_drive_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int job_hs0 = 0;
  int ready_mode = 0;       // 0 high, 1 low, 2 random with at most 3 low cycles

  task automatic check(input string tag, input logic [295:0] got, input logic [295:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rq(input logic [31:0] x, input int sh);
    longint v;
    v = longint'($signed(x));
`ifdef WB_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v >>> sh;
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  task automatic push_model(input int n, input logic [7:0] base, input int sh);
    logic [255:0] d;
    logic [31:0]  m;
    logic [7:0]   a;
    int s;
    a = base; d = '0; m = '0; s = 0;
    for (int w = 0; w < n; w++) begin
      for (int l = 0; l < 8; l++) d[s*64 + l*8 +: 8] = rq(words[w][l*32 +: 32], sh);
      m[s*8 +: 8] = 8'hFF;
      s++;
      if (s == 4 || w == n - 1) begin
        exp_q.push_back({a, m, d});
        a = a + 8'd1; d = '0; m = '0; s = 0;
      end
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    int lows;
    lows = 0;
    ub_wr_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0: ub_wr_ready = 1'b1;
        1: ub_wr_ready = 1'b0;
        default: begin
          if (lows >= 3 || $urandom_range(1, 0) == 1) begin
            ub_wr_ready = 1'b1; lows = 0;
          end else begin
            ub_wr_ready = 1'b0; lows++;
          end
        end
      endcase
    end
  end

  // ---------------- write monitor / scoreboard ----------------
  logic         hold_prev = 1'b0;
  logic [295:0] prev_out;

  always @(negedge clk) begin
    logic [295:0] e;
    logic [255:0] bm;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_en", ub_wr_en, 1'b1);
        check("hold_out", {ub_wr_addr, ub_wr_mask, ub_wr_data}, prev_out);
      end
      hold_prev = ub_wr_en && !ub_wr_ready;
      prev_out  = {ub_wr_addr, ub_wr_mask, ub_wr_data};
      if (ub_wr_en && ub_wr_ready) begin
        hs_count++;
        last_hs_cyc = cyc;
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          bm = '0;
          for (int b = 0; b < 32; b++) if (e[256 + b]) bm[b*8 +: 8] = 8'hFF;
          check("wr_addr", ub_wr_addr, e[295:288]);
          check("wr_mask", ub_wr_mask, e[287:256]);
          check("wr_data", ub_wr_data & bm, e[255:0] & bm);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input logic [7:0] base, input int count, input int n_drive,
                         input int sh, input int gap_max, input int n_model);
    if (n_model > 0) push_model(n_model, base, sh);
    @(posedge clk); #1;
    wb_start = 1'b1; wb_base_addr = base; wb_count = 8'(count); wb_shift = 5'(sh);
    start_cyc = cyc;
    job_hs0 = hs_count;
    @(posedge clk); #1;
    wb_start = 1'b0;
    for (int w = 0; w < n_drive; w++) begin
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = words[w];
      last_drive_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = {8{$urandom}};
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lines);
    int n;
    n = 0;
    @(negedge clk);
    while (!wb_done && n < 400) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, wb_done, 1'b1);
    done_cyc = cyc;
    if (exp_lines > 0) check({tag, "_done_lat"}, done_cyc, last_hs_cyc + 1);
    else               check({tag, "_done_lat"}, done_cyc, start_cyc + 1);
    check({tag, "_lines"}, hs_count - job_hs0, exp_lines);
    @(negedge clk);
    check({tag, "_done_pulse"}, wb_done, 1'b0);
    check({tag, "_idle"}, wb_busy, 1'b0);
  endtask

  task automatic rand_words(input int n);
    for (int w = 0; w < n; w++)
      for (int l = 0; l < 8; l++)
        words[w][l*32 +: 32] = ($urandom_range(1, 0) == 1) ? $urandom
                               : 32'($urandom_range(4000, 0)) - 32'd2000;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [63:0] exp_slot0;
    rst_n = 1'b0; wb_start = 1'b0; wb_base_addr = '0; wb_count = '0; wb_shift = '0;
    in_data = '0; in_valid = 1'b0;

    #12;
    check("rst_en", ub_wr_en, 1'b0);
    check("rst_addr", ub_wr_addr, 8'h00);
    check("rst_data", ub_wr_data, 256'h0);
    check("rst_mask", ub_wr_mask, 32'h0);
    check("rst_busy", wb_busy, 1'b0);
    check("rst_done", wb_done, 1'b0);
    check("rst_ovf", wb_overflow, 1'b0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk); rst_n = 1'b1;

    // in_valid while IDLE must not produce any write
    @(posedge clk); #1; in_valid = 1'b1; in_data = {8{$urandom}};
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_write", hs_count, 0);

    // T1: lanes = lane index, shift 0, one full line at 0x10
    for (int w = 0; w < 4; w++)
      for (int l = 0; l < 8; l++) words[w][l*32 +: 32] = 32'(l);
    ready_mode = 0;
    run_job(8'h10, 4, 4, 0, 0, 4);
    wait_done("t1", 1);
    check("t1_wr_latency", last_hs_cyc - last_drive_cyc, 3);

    // T2: saturation / shift corner values in lanes 0..3, shift 4
    words[0] = '0;
    words[0][31:0]   = 32'h00001000;
    words[0][63:32]  = 32'hFFFFF000;
    words[0][95:64]  = 32'd200;
    words[0][127:96] = 32'hFFFFFF38;
`ifdef WB_ROUND_EN
    exp_slot0 = 64'h00000000_F40D807F;
`else
    exp_slot0 = 64'h00000000_F30C807F;
`endif
    exp_q.push_back({8'h40, 32'h000000FF, 192'h0, exp_slot0});
    run_job(8'h40, 1, 1, 4, 0, 0);
    wait_done("t2", 1);

    // T3: address wrap and partial trailing line
    rand_words(6);
    run_job(8'hFF, 6, 6, 3, 1, 6);
    wait_done("t3", 2);

    // T4: ready held low for 10 cycles, outputs must hold
    rand_words(4);
    ready_mode = 1;
    run_job(8'h80, 4, 4, 7, 0, 4);
    repeat (10) @(negedge clk);
    check("t4_en_held", ub_wr_en, 1'b1);
    check("t4_no_write_yet", hs_count - job_hs0, 0);
    ready_mode = 0;
    wait_done("t4", 1);
    check("t4_ovf", wb_overflow, 1'b0);

    // T5: overflow, 9 back-to-back words with ready low; the 9th is dropped
    rand_words(9);
    ready_mode = 1;
    run_job(8'h50, 9, 9, 2, 0, 8);
    repeat (3) @(negedge clk);
    check("t5_ovf_set", wb_overflow, 1'b1);
    check("t5_busy", wb_busy, 1'b1);
    ready_mode = 0;
    wait_done("t5", 2);
    check("t5_ovf_sticky", wb_overflow, 1'b1);
    run_job(8'h00, 0, 0, 0, 0, 0);
    wait_done("t5_zero", 0);
    check("t5_ovf_cleared", wb_overflow, 1'b0);

    // Random jobs with random ready and input gaps
    ready_mode = 2;
    for (int j = 0; j < 5; j++) begin
      n = $urandom_range(20, 1);
      rand_words(n);
      run_job(8'($urandom), n, n, $urandom_range(31, 0), 2, n);
      wait_done("rnd", (n + 3) / 4);
      check("rnd_ovf", wb_overflow, 1'b0);
    end
    ready_mode = 0;

    // T6: asynchronous reset mid-RUN with a write pending
    rand_words(4);
    ready_mode = 1;
    run_job(8'h20, 8, 4, 1, 0, 0);
    n = 0;
    while (!ub_wr_en && n < 20) begin @(negedge clk); n++; end
    check("t6_pre_en", ub_wr_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_en", ub_wr_en, 1'b0);
    check("t6_addr", ub_wr_addr, 8'h00);
    check("t6_data", ub_wr_data, 256'h0);
    check("t6_mask", ub_wr_mask, 32'h0);
    check("t6_busy", wb_busy, 1'b0);
    check("t6_done", wb_done, 1'b0);
    check("t6_ovf", wb_overflow, 1'b0);
    exp_q.delete();
    ready_mode = 0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_job(8'h33, 0, 0, 0, 0, 0);
    wait_done("t6_zero", 0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
